tc_stack_ctrl: RTL and testbench

LIFO stack controller that sits directly upstream of the 256×8 TC RAM block and drives its load/save/address/in pins while consuming its registered read data. Converts single-cycle push/pop requests into correctly timed RAM write (negedge-sampled) and read (posedge-registered) accesses. Tracks the stack pointer, full/empty status and sticky error flags. The RAM's clear-on-reset and this block's reset share the same `rst`.

---
 rtl/tc_stack_ctrl.sv | 158 +++++++++++++++
 tb/tb_tc_stack_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_stack_ctrl.sv
// LIFO stack controller in front of the 256x8 TC RAM.
// Turns single-cycle push/pop requests into timed RAM save/load accesses,
// and tracks the stack pointer, full/empty status and sticky error flags.
module tc_stack_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       clr_err,
    input  logic [7:0] din,
    output logic       ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [8:0] count,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       unf,
    output logic       ram_load,
    output logic       ram_save,
    output logic [7:0] ram_address,
    output logic [7:0] ram_in,
    input  logic [7:0] ram_out
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SP_W    = 9;
    localparam int unsigned DEPTH   = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                ram_load_q, ram_load_d;
    logic                ram_save_q, ram_save_d;
    logic [DATA_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_in_q, ram_in_d;
    logic                ready_q, ready_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;

    // Next-state, pointer, error and RAM-control decisions.
    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;

        // Clear first so an error detected on the same edge wins.
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_in_d      = din;
                        ram_address_d = sp_q[DATA_W-1:0];
                        sp_d          = sp_q + SP_W'(1);
                        state_d       = ST_WRITE;
                    end
                end else if (pop) begin
                    if (empty_q) begin
                        unf_d = 1'b1;
                    end else begin
                        sp_d          = sp_q - SP_W'(1);
                        ram_address_d = sp_d[DATA_W-1:0];
                        state_d       = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                dout_d       = ram_out;
                dout_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ram_save_d = (state_d == ST_WRITE);
        ram_load_d = (state_d == ST_READ);
        ready_d    = (state_d == ST_IDLE);
        full_d     = (sp_d == SP_W'(DEPTH));
        empty_d    = (sp_d == '0);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sp_q          <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            ram_load_q    <= 1'b0;
            ram_save_q    <= 1'b0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            ready_q       <= 1'b1;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            ram_load_q    <= ram_load_d;
            ram_save_q    <= ram_save_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            ready_q       <= ready_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

    assign ready       = ready_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign count       = sp_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign ram_load    = ram_load_q;
    assign ram_save    = ram_save_q;
    assign ram_address = ram_address_q;
    assign ram_in      = ram_in_q;

endmodule

// File: tb/tb_tc_stack_ctrl.sv
// Bench for tc_stack_ctrl: behavioural 256x8 RAM plus a queue-based LIFO
// reference, directed scenarios followed by a randomized request stream.
module tb_tc_stack_ctrl;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] din;
    logic       ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic [8:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       ram_load;
    logic       ram_save;
    logic [7:0] ram_address;
    logic [7:0] ram_in;
    logic [7:0] ram_out;

    tc_stack_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .din         (din),
        .ready       (ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .ovf         (ovf),
        .unf         (unf),
        .ram_load    (ram_load),
        .ram_save    (ram_save),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_out     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TC RAM model: negedge write on save, posedge-registered read on load.
    logic [7:0] mem [256];
    logic [7:0] out_q;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (ram_save) begin
            mem[ram_address] <= ram_in;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst)           out_q <= 8'h00;
        else if (ram_load) out_q <= mem[ram_address];
    end

    assign ram_out = out_q;

    // Reference model state.
    logic [7:0] stk [$];
    logic       ovf_m;
    logic       unf_m;
    logic [7:0] dout_m;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(stk.size()));
        chk({tag, "_full"},  32'(full),  32'(stk.size() == 256));
        chk({tag, "_empty"}, 32'(empty), 32'(stk.size() == 0));
        chk({tag, "_ovf"},   32'(ovf),   32'(ovf_m));
        chk({tag, "_unf"},   32'(unf),   32'(unf_m));
    endtask

    task automatic model_reset();
        stk.delete();
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
        dout_m = 8'h00;
    endtask

    // One request in IDLE, then follow the transaction it starts to completion.
    task automatic do_req(input logic p, input logic o, input logic [7:0] d, input logic c);
        int         w;
        logic       push_ok;
        logic       pop_ok;
        logic [7:0] exp_d;
        w = 0;
        @(negedge clk);
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            return;
        end
        push = p; pop = o; din = d; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;

        push_ok = 1'b0;
        pop_ok  = 1'b0;
        exp_d   = 8'h00;
        if (c) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end
        if (p) begin
            if (stk.size() == 256) ovf_m = 1'b1;
            else begin
                stk.push_back(d);
                push_ok = 1'b1;
            end
        end else if (o) begin
            if (stk.size() == 0) unf_m = 1'b1;
            else begin
                exp_d  = stk.pop_back();
                pop_ok = 1'b1;
            end
        end

        chk_status("req");
        chk("save_pulse", 32'(ram_save), 32'(push_ok));
        chk("load_pulse", 32'(ram_load), 32'(pop_ok));
        chk("ready_busy", 32'(ready), 32'(!(push_ok || pop_ok)));
        if (push_ok) begin
            chk("wr_addr", 32'(ram_address), 32'(stk.size() - 1));
            chk("wr_data", 32'(ram_in), 32'(d));
            @(posedge clk);
            #1;
            chk("save_end", 32'(ram_save), 32'd0);
            chk("ready_after_push", 32'(ready), 32'd1);
        end else if (pop_ok) begin
            chk("rd_addr", 32'(ram_address), 32'(stk.size()));
            @(posedge clk);
            #1;
            chk("load_end", 32'(ram_load), 32'd0);
            chk("valid_early", 32'(dout_valid), 32'd0);
            @(posedge clk);
            #1;
            dout_m = exp_d;
            chk("pop_valid", 32'(dout_valid), 32'd1);
            chk("pop_data", 32'(dout), 32'(dout_m));
            chk("ready_after_pop", 32'(ready), 32'd1);
        end else begin
            chk("dout_hold", 32'(dout), 32'(dout_m));
            chk("valid_quiet", 32'(dout_valid), 32'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 8'h00;
        model_reset();

        // Power-on reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_status("rst");
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Push then pop returns in reverse order.
        do_req(1'b1, 1'b0, 8'h11, 1'b0);
        do_req(1'b1, 1'b0, 8'h22, 1'b0);
        do_req(1'b1, 1'b0, 8'h33, 1'b0);
        repeat (3) do_req(1'b0, 1'b1, 8'h00, 1'b0);

        // Underflow, then clear.
        do_req(1'b0, 1'b1, 8'h00, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 1'b1);

        // Fill to 256, overflow, overflow with clr on same edge, pop 0xFF.
        for (int i = 0; i < 256; i++) do_req(1'b1, 1'b0, 8'(i), 1'b0);
        do_req(1'b1, 1'b0, 8'hA5, 1'b0);
        do_req(1'b1, 1'b0, 8'hA6, 1'b1);
        do_req(1'b0, 1'b1, 8'h00, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 1'b1);

        // Drain to one entry, then simultaneous push+pop.
        while (stk.size() > 1) do_req(1'b0, 1'b1, 8'h00, 1'b0);
        do_req(1'b1, 1'b1, 8'h5A, 1'b0);
        do_req(1'b0, 1'b1, 8'h00, 1'b0);

        // Asynchronous reset while a pop is in READ.
        do_req(1'b1, 1'b0, 8'h77, 1'b0);
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        chk("mid_in_read", 32'(ram_load), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_status("mid_rst");
        chk("mid_ready", 32'(ready), 32'd1);
        chk("mid_load", 32'(ram_load), 32'd0);
        chk("mid_dout", 32'(dout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("mid_no_valid", 32'(dout_valid), 32'd0);
        end
        do_req(1'b0, 1'b1, 8'h00, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized request stream.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 5)       do_req(1'b1, 1'b0, 8'($urandom), 1'b0);
            else if (r < 8)  do_req(1'b0, 1'b1, 8'h00, 1'b0);
            else if (r == 8) do_req(1'b1, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
            else             do_req(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end
        while (stk.size() > 0) do_req(1'b0, 1'b1, 8'h00, 1'b0);
        do_req(1'b0, 1'b1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
